vedic_mul8_seq_ctrl: RTL and testbench
======================================

Name: vedic_mul8_seq_ctrl

Overview:
- Sequential 8x8 unsigned multiplier controller that time-shares one internal vedic_4bit_mul instance across four nibble partial products.
- Accepts operands on a valid/ready input handshake, accumulates the partial products over four cycles, and presents a 16-bit product on a valid/ready output handshake.
- Sits between an operand source and a result consumer wherever area matters more than throughput.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  controller can accept operands.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  16  a*b, unsigned.
- busy  output  1  high in CALC or DONE.
- op_count  output  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, phase=0, acc=0, a_q=0, b_q=0, op_count=0.
  - in_ready=1, out_valid=0, busy=0, product=0.
- States:
  - IDLE: in_ready=1. If in_valid at an edge: capture a_q=a, b_q=b, acc=0, phase=0, go to CALC.
  - CALC: in_ready=0. Each edge adds the current phase's partial product to acc and increments phase. At the edge that completes phase 3, go to DONE.
  - DONE: out_valid=1. If out_ready at an edge: go to IDLE and increment op_count.
- Multiplier operand mux, driven from phase (2-bit):
  - phase 0: a_q[3:0]*b_q[3:0], shift 0.
  - phase 1: a_q[3:0]*b_q[7:4], shift 4.
  - phase 2: a_q[7:4]*b_q[3:0], shift 4.
  - phase 3: a_q[7:4]*b_q[7:4], shift 8.
  - The 8-bit partial product is zero-extended to 16 bits, shifted, and added to acc.
  - acc is 16 bits and cannot overflow (max 255*255=0xFE01).
- Latency:
  - Accept at edge k; acc final at edge k+4; out_valid=1 from edge k+4.
  - Minimum spacing between accepts is 6 cycles: handshake at edge k+5, next accept at k+6.
- product:
  - Driven from acc only while out_valid=1; 0 otherwise.
  - Held stable while out_valid=1 and out_ready=0, for any duration (backpressure).
- in_ready=(state==IDLE). in_valid outside IDLE is ignored; a and b may change freely there without affecting the result.
- out_ready while not in DONE has no effect.
- busy = (state != IDLE).
- op_count increments only on an out_valid & out_ready edge. It wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-CALC or mid-DONE: all outputs and state return to reset values immediately (asynchronously). The in-flight operation is dropped and not counted.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
1. Reset, then a=0x12, b=0x34 with in_valid pulsed 1 cycle and out_ready=1 -> out_valid rises 4 cycles after accept with product=0x03A8; next edge in_ready=1, op_count=1.
2. a=0xFF, b=0xFF -> product=0xFE01. Then a=0x00, b=0xA5 -> product=0x0000. Then a=0x0F, b=0xF0 -> product=0x0E10.
3. Backpressure: a=0x0B, b=0x07, out_ready=0 for 10 cycles -> out_valid and product=0x004D held stable, in_ready=0, op_count unchanged. Raise out_ready -> one handshake, op_count+1.
4. Hold in_valid=1 continuously while toggling a/b every cycle during CALC/DONE -> only the operands sampled in IDLE are used; exactly one accept per IDLE visit; each product matches the operands captured at that accept.
5. Assert rst during phase 2 of a=0xC8, b=0x03 -> outputs go to reset values immediately without a clock edge. After release, a=0xC8, b=0x03 -> product=0x0258, op_count=1.
6. CNT_W=2, five back-to-back operations -> op_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vedic_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul8_seq_ctrl
// Purpose  : 8x8 unsigned multiplier built from one shared 4x4 Vedic core,
//            one nibble partial product per cycle, valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================

module vedic_2bit_mul (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;

  // Urdhva-Tiryagbhyam: vertical and crosswise products with one carry
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule

module vedic_4bit_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;

  vedic_2bit_mul u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
  vedic_2bit_mul u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
  vedic_2bit_mul u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
  vedic_2bit_mul u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

  assign p = {4'b0000, w_q0}
           + {2'b00, w_q1, 2'b00}
           + {2'b00, w_q2, 2'b00}
           + {w_q3, 4'b0000};
endmodule

module vedic_mul8_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_phase;
  logic [15:0]      r_acc;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]  w_mul_a;
  logic [3:0]  w_mul_b;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_shifted;

  // Nibble selection and weight for the partial product of this phase
  always_comb begin
    w_mul_a      = r_a[3:0];
    w_mul_b      = r_b[3:0];
    w_pp_shifted = {8'h00, w_pp};
    case (r_phase)
      2'd0: begin
        w_mul_a      = r_a[3:0];
        w_mul_b      = r_b[3:0];
        w_pp_shifted = {8'h00, w_pp};
      end
      2'd1: begin
        w_mul_a      = r_a[3:0];
        w_mul_b      = r_b[7:4];
        w_pp_shifted = {4'h0, w_pp, 4'h0};
      end
      2'd2: begin
        w_mul_a      = r_a[7:4];
        w_mul_b      = r_b[3:0];
        w_pp_shifted = {4'h0, w_pp, 4'h0};
      end
      default: begin
        w_mul_a      = r_a[7:4];
        w_mul_b      = r_b[7:4];
        w_pp_shifted = {w_pp, 8'h00};
      end
    endcase
  end

  vedic_4bit_mul u_core (.a(w_mul_a), .b(w_mul_b), .p(w_pp));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)          w_next = S_CALC;
      S_CALC:  if (r_phase == 2'd3)   w_next = S_DONE;
      S_DONE:  if (out_ready)         w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 2'd0;
      r_acc   <= 16'h0000;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= 16'h0000;
            r_phase <= 2'd0;
          end
        end
        S_CALC: begin
          r_acc   <= r_acc + w_pp_shifted;
          r_phase <= r_phase + 2'd1;
        end
        S_DONE: begin
          if (out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_phase <= 2'd0;
        end
      endcase
    end
  end

  // All outputs decode from registered state only
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign product   = out_valid ? r_acc : 16'h0000;
  assign op_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vedic_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mul8_seq_ctrl
// Purpose  : Directed scoreboard bench for the sequential Vedic multiplier.
// Revision : 1.0  initial release
// ============================================================================

module tb_vedic_mul8_seq_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               n_vec = 0;
  int               n_err = 0;
  logic [15:0]      exp_q[$];
  logic [CNT_W-1:0] model_cnt = '0;

  vedic_mul8_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented product against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      model_cnt = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: got product 0x%0h expected none", product);
      end else begin
        check("product", 32'(product), 32'(exp_q[0]));
        if (out_ready) begin
          check("op_count_model", 32'(op_count), 32'(model_cnt));
          void'(exp_q.pop_front());
          model_cnt = model_cnt + 1'b1;
        end
      end
    end else begin
      check("product_idle_zero", 32'(product), 32'h0);
    end
  end

  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] ex);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("issue_timeout", 32'(in_ready), 32'h1);
    end else begin
      a = va;
      b = vb;
      in_valid = 1'b1;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!(in_ready && exp_q.size() == 0))
      check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  logic [7:0]  t4_a [12] = '{8'h21, 8'h5A, 8'hFF, 8'h01, 8'h77, 8'h3C,
                             8'h9C, 8'hE0, 8'h0D, 8'hAA, 8'h66, 8'h81};
  logic [7:0]  t4_b [12] = '{8'h13, 8'hC3, 8'h80, 8'hFE, 8'h44, 8'h99,
                             8'h45, 8'h12, 8'hF0, 8'h55, 8'h07, 8'h3E};
  logic [15:0] t4_e [2]  = '{16'h0273, 16'h2A0C};
  logic [7:0]  t6_a [5]  = '{8'h03, 8'h05, 8'h07, 8'h09, 8'h0B};
  logic [15:0] t6_e [5]  = '{16'h0030, 16'h0050, 16'h0070, 16'h0090, 16'h00B0};
  logic [CNT_W-1:0] t6_prev [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_product", 32'(product), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: latency of exactly four cycles after accept
    issue(8'h12, 8'h34, 16'h03A8);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 check("t1_latency_low", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    #1 check("t1_latency_high", 32'(out_valid), 32'h1);
    check("t1_product", 32'(product), 32'h03A8);
    @(posedge clk);
    #1 check("t1_in_ready", 32'(in_ready), 32'h1);
    check("t1_op_count", 32'(op_count), 32'h1);

    // Test 2: corner operands
    issue(8'hFF, 8'hFF, 16'hFE01);
    issue(8'h00, 8'hA5, 16'h0000);
    issue(8'h0F, 8'hF0, 16'h0E10);
    wait_drain();
    check("t2_op_count", 32'(op_count), 32'h0);

    // Test 3: backpressure holds result and count
    out_ready = 1'b0;
    issue(8'h0B, 8'h07, 16'h004D);
    repeat (14) @(posedge clk);
    #1 check("t3_out_valid", 32'(out_valid), 32'h1);
    check("t3_product", 32'(product), 32'h004D);
    check("t3_in_ready", 32'(in_ready), 32'h0);
    check("t3_busy", 32'(busy), 32'h1);
    check("t3_op_count", 32'(op_count), 32'h0);
    out_ready = 1'b1;
    wait_drain();
    check("t3_op_count_after", 32'(op_count), 32'h1);

    // Test 4: in_valid held high, operands churning every cycle
    for (int i = 0; i < 12; i++) begin
      a = t4_a[i];
      b = t4_b[i];
      in_valid = 1'b1;
      check("t4_in_ready", 32'(in_ready), 32'(i % 6 == 0));
      if (i % 6 == 0) exp_q.push_back(t4_e[i / 6]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();
    check("t4_op_count", 32'(op_count), 32'h3);

    // Test 5: asynchronous reset during phase 2
    issue(8'hC8, 8'h03, 16'h0258);
    @(posedge clk);
    @(posedge clk);
    #2 check("t5_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'h0);
    check("t5_rst_in_ready", 32'(in_ready), 32'h1);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_product", 32'(product), 32'h0);
    check("t5_rst_op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(8'hC8, 8'h03, 16'h0258);
    wait_drain();
    check("t5_op_count", 32'(op_count), 32'h1);

    // Test 6: count wraps with a narrow counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      issue(t6_a[j], 8'h10, t6_e[j]);
      check("t6_op_count_seq", 32'(op_count), 32'(t6_prev[j]));
    end
    wait_drain();
    check("t6_op_count_final", 32'(op_count), 32'h1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
